buffer_reader_tx: RTL

BUFFER_READER_TX -- requirements
Module: buffer_reader_tx

---
 rtl/buffer_reader_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/buffer_reader_tx.sv
// ============================================================================
//  buffer_reader_tx
//  Pops one word from an upstream buffer and sends it as a UART-style frame.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module buffer_reader_tx #(
  parameter int DATA_W       = 9,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_out_valid,
  output logic              data_out_read,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               tx_q, tx_d;
  logic               read_q, read_d;
  logic               baud_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (en && data_out_valid) state_d = S_READ;
      end
      S_READ: begin
        // The word is taken on the same edge the strobe is retired.
        if (data_out_valid) begin
          state_d = S_START;
          shift_d = data_out;
          baud_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          state_d = S_IDLE;
          baud_d  = '0;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level and strobe follow the next state so both leave a flop.
    read_d = (state_d == S_READ);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign data_out_read = read_q;
  assign tx            = tx_q;
  assign busy          = (state_q != S_IDLE);
  assign word_cnt      = cnt_q;

endmodule

`default_nettype wire
